// File: rtl/i2c_byte_rx.sv
// i2c_byte_rx: I2C slave byte receiver (write-only). It acknowledges its
// 7-bit address (write direction only) and then each data byte the consumer
// can accept, presenting every accepted byte on rx_data with a one-clk
// rx_valid pulse.
// Optional build macro: I2C_RX_GLITCH_FILTER_EN adds a 3-sample glitch filter
// on the synchronized SCL/SDA. This adds 2 clk of latency and rejects pulses
// of 2 clk or less.
// Handshake: rx_valid is a one-clk strobe with no back-pressure. rx_full is
// sampled when the 8th data bit is clocked in; if it is high, the byte is
// NACKed and dropped.
module i2c_byte_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] rx_data_n;
  logic       sda_oe_n, rx_valid_n, busy_n, addr_match_n;

  logic scl_meta, scl_sync, sda_meta, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;

  // Two-flop synchronizers; preset high so reset looks like an idle bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
    end
  end

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic scl_h1, scl_h2, scl_f, sda_h1, sda_h2, sda_f;

  // Sample history plus held value; a level passes only when 3 samples agree.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_h1 <= 1'b1;
      scl_h2 <= 1'b1;
      scl_f  <= 1'b1;
      sda_h1 <= 1'b1;
      sda_h2 <= 1'b1;
      sda_f  <= 1'b1;
    end else begin
      scl_h1 <= scl_sync;
      scl_h2 <= scl_h1;
      scl_f  <= scl_s;
      sda_h1 <= sda_sync;
      sda_h2 <= sda_h1;
      sda_f  <= sda_s;
    end
  end

  assign scl_s = (scl_sync == scl_h1 && scl_h1 == scl_h2) ? scl_sync : scl_f;
  assign sda_s = (sda_sync == sda_h1 && sda_h1 == sda_h2) ? sda_sync : sda_f;
`else
  assign scl_s = scl_sync;
  assign sda_s = sda_sync;
`endif

  // One-clk delayed copies for edge and condition detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] shift_in;

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign shift_in = {shift_q[6:0], sda_s};

  assign dbg_state = state_q;

  // State and output registers; reset aborts any transfer and drops SDA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'h00;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      sda_oe     <= sda_oe_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      busy       <= busy_n;
      addr_match <= addr_match_n;
    end
  end

  // Next-state logic; bus conditions override SCL-edge handling.
  always_comb begin
    state_n      = state_q;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift_q;
    sda_oe_n     = sda_oe;
    rx_data_n    = rx_data;
    rx_valid_n   = 1'b0;
    busy_n       = busy;
    addr_match_n = addr_match;
    if (start_c) begin
      state_n      = ADDR;
      bit_cnt_n    = 3'd0;
      shift_n      = 8'h00;
      sda_oe_n     = 1'b0;
      busy_n       = 1'b1;
      addr_match_n = 1'b0;
    end else if (stop_c) begin
      state_n      = IDLE;
      bit_cnt_n    = 3'd0;
      sda_oe_n     = 1'b0;
      busy_n       = 1'b0;
      addr_match_n = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR && !shift_in[0]) begin
                state_n      = ADDR_ACK;
                addr_match_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!rx_full) begin
                rx_data_n  = shift_in;
                rx_valid_n = 1'b1;
                state_n    = DATA_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // First fall drives the ACK bit, second fall ends it.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = DATA;
            end
          end
        end
        IGNORE: sda_oe_n = 1'b0;
        IDLE:   sda_oe_n = 1'b0;
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_rx.sv
// tb_i2c_byte_rx: directed I2C master transactions against i2c_byte_rx.
// Bus-level expectations come from protocol rules applied by the drivers and
// are delivered to the compare process after the fixed detection latency.
module tb_i2c_byte_rx;

  localparam logic [6:0] SLAVE_ADDR = 7'h50;
  localparam int Q = 6;
`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  localparam int F_BUSY = 0, F_MATCH = 1, F_OE = 2, F_VALID = 3, F_DATA = 4, F_RST = 5;
  localparam int PH_IDLE = 0, PH_ADDR = 1, PH_ACK = 2, PH_DATA = 3, PH_IGN = 4;

  typedef struct {
    int         due;
    int         fld;
    logic [7:0] val;
  } ev_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       scl_drv, sda_drv, rx_full;
  logic       sda_oe, rx_valid, busy, addr_match;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;
  logic       scl_in, sda_in;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_byte_rx #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .rx_full    (rx_full),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .addr_match (addr_match),
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int         checks = 0;
  int         failures = 0;
  logic       started = 1'b0;
  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  logic       m_busy = 1'b0, m_match = 1'b0, m_oe = 1'b0, m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_phase = PH_IDLE;
  logic       m_ack = 1'b0;
  int         n_ack = 0, n_valid = 0, n_match = 0;
  logic       oe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sched(input int fld, input logic [7:0] val, input int extra);
    ev_q.push_back('{cyc + LAT + extra, fld, val});
  endtask

  task automatic sched_start();
    sched(F_BUSY, 8'd1, 0);
    sched(F_MATCH, 8'd0, 0);
    sched(F_OE, 8'd0, 0);
    m_phase = PH_ADDR;
  endtask

  task automatic sched_stop();
    sched(F_BUSY, 8'd0, 0);
    sched(F_MATCH, 8'd0, 0);
    sched(F_OE, 8'd0, 0);
    m_phase = PH_IDLE;
  endtask

  task automatic apply_ev(input ev_t e);
    case (e.fld)
      F_BUSY:  m_busy  = e.val[0];
      F_MATCH: m_match = e.val[0];
      F_OE:    m_oe    = e.val[0];
      F_VALID: m_valid = e.val[0];
      F_DATA:  m_data  = e.val;
      default: begin
        m_busy = 1'b0; m_match = 1'b0; m_oe = 1'b0; m_valid = 1'b0; m_data = 8'h00;
      end
    endcase
  endtask

  // compare process: every cycle once reset has taken effect
  always @(negedge clk) begin
    int i;
    if (started) begin
      i = 0;
      while (i < ev_q.size()) begin
        if (ev_q[i].due <= cyc) begin
          apply_ev(ev_q[i]);
          ev_q.delete(i);
        end else begin
          i++;
        end
      end
      check("busy", busy, m_busy);
      check("addr_match", addr_match, m_match);
      check("sda_oe", sda_oe, m_oe);
      check("rx_valid", rx_valid, m_valid);
      check("rx_data", rx_data, m_data);
      if (rx_valid === 1'b1) begin
        check("rx_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", rx_data, exp_q.pop_front());
        n_valid++;
      end
      if (sda_oe === 1'b1 && oe_prev === 1'b0) n_ack++;
      if (addr_match === 1'b1) n_match++;
      oe_prev = sda_oe;
    end
  end

  // protocol rules applied when the 8th bit is clocked
  task automatic decide_byte(input logic [7:0] val);
    m_ack = 1'b0;
    case (m_phase)
      PH_ADDR: begin
        if (val[7:1] == SLAVE_ADDR && val[0] == 1'b0) begin
          m_ack = 1'b1;
          m_phase = PH_ACK;
          sched(F_MATCH, 8'd1, 0);
        end else begin
          m_phase = PH_IGN;
        end
      end
      PH_DATA: begin
        if (!rx_full) begin
          m_ack = 1'b1;
          m_phase = PH_ACK;
          sched(F_DATA, val, 0);
          sched(F_VALID, 8'd1, 0);
          sched(F_VALID, 8'd0, 1);
          exp_q.push_back(val);
        end else begin
          m_phase = PH_IGN;
        end
      end
      default: ;
    endcase
  endtask

  // driver tasks
  task automatic i2c_start();
    if (scl_drv == 1'b0) begin
      sda_drv = 1'b1;
      wait_clks(Q);
      scl_drv = 1'b1;
      wait_clks(Q);
    end
    sda_drv = 1'b0;
    sched_start();
    wait_clks(Q);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(Q);
    sda_drv = 1'b1;
    sched_stop();
    wait_clks(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] val, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      sda_drv = val[7 - i];
      wait_clks(Q);
      scl_drv = 1'b1;
      if (i == 7) decide_byte(val);
      if (i == glitch_bit) begin
        wait_clks(4);
        sda_drv = 1'b0;
`ifndef I2C_RX_GLITCH_FILTER_EN
        sched_start();
`endif
        wait_clks(1);
        sda_drv = val[7 - i];
`ifndef I2C_RX_GLITCH_FILTER_EN
        sched_stop();
`endif
        wait_clks(2 * Q - 5);
      end else begin
        wait_clks(2 * Q);
      end
      scl_drv = 1'b0;
      if (i == 7 && m_ack) sched(F_OE, 8'd1, 0);
      wait_clks(Q);
    end
  endtask

  task automatic ack_clock();
    sda_drv = 1'b1;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(2 * Q);
    scl_drv = 1'b0;
    if (m_phase == PH_ACK) begin
      sched(F_OE, 8'd0, 0);
      m_phase = PH_DATA;
    end
    wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] val, input int glitch_bit);
    send_bits(val, 8, glitch_bit);
    ack_clock();
  endtask

  task automatic clear_counts();
    n_ack = 0;
    n_valid = 0;
    n_match = 0;
  endtask

  task automatic do_reset();
    ev_q.delete();
    ev_q.push_back('{cyc + 1, F_RST, 8'h00});
    m_phase = PH_IDLE;
    reset = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(1);
  endtask

  initial begin
    reset = 1'b0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    rx_full = 1'b0;
    wait_clks(1);
    started = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_state_idle", dbg_state, 0);
    wait_clks(4);

    // write 0x50, data 0x3C
    clear_counts();
    i2c_start();
    send_byte(8'hA0, -1);
    send_byte(8'h3C, -1);
    i2c_stop();
    wait_clks(LAT + 4);
    check("s1_acks", n_ack, 2);
    check("s1_valid_pulses", n_valid, 1);
    check("s1_rx_data", rx_data, 8'h3C);
    check("s1_busy", busy, 0);

    // address 0x51 write: ignored
    clear_counts();
    i2c_start();
    send_byte(8'hA2, -1);
    send_byte(8'h77, -1);
    wait_clks(2);
    check("s2_busy_in_ignore", busy, 1);
    i2c_stop();
    wait_clks(LAT + 4);
    check("s2_acks", n_ack, 0);
    check("s2_valid_pulses", n_valid, 0);
    check("s2_match_cycles", n_match, 0);
    check("s2_busy", busy, 0);

    // address 0x50 read: NACK
    clear_counts();
    i2c_start();
    send_byte(8'hA1, -1);
    send_byte(8'h55, -1);
    i2c_stop();
    wait_clks(LAT + 4);
    check("s3_acks", n_ack, 0);
    check("s3_valid_pulses", n_valid, 0);

    // consumer full on second byte
    clear_counts();
    i2c_start();
    send_byte(8'hA0, -1);
    send_byte(8'h11, -1);
    rx_full = 1'b1;
    send_byte(8'h22, -1);
    rx_full = 1'b0;
    i2c_stop();
    wait_clks(LAT + 4);
    check("s4_acks", n_ack, 2);
    check("s4_valid_pulses", n_valid, 1);
    check("s4_rx_data", rx_data, 8'h11);

    // partial byte then repeated START
    clear_counts();
    i2c_start();
    send_byte(8'hA0, -1);
    send_bits(8'hA0, 4, -1);
    i2c_start();
    send_byte(8'hA0, -1);
    send_byte(8'h5A, -1);
    i2c_stop();
    wait_clks(LAT + 4);
    check("s5_acks", n_ack, 3);
    check("s5_valid_pulses", n_valid, 1);
    check("s5_rx_data", rx_data, 8'h5A);

    // 1-clk SDA low glitch while SCL high during a data byte of 0xFF
    clear_counts();
    i2c_start();
    send_byte(8'hA0, -1);
    send_bits(8'hFF, 8, 3);
`ifdef I2C_RX_GLITCH_FILTER_EN
    check("s6_busy_after_glitch", busy, 1);
`else
    check("s6_busy_after_glitch", busy, 0);
`endif
    ack_clock();
    i2c_stop();
    wait_clks(LAT + 4);
`ifdef I2C_RX_GLITCH_FILTER_EN
    check("s6_acks", n_ack, 2);
    check("s6_valid_pulses", n_valid, 1);
    check("s6_rx_data", rx_data, 8'hFF);
`else
    check("s6_acks", n_ack, 1);
    check("s6_valid_pulses", n_valid, 0);
    check("s6_rx_data", rx_data, 8'h5A);
`endif

    // reset while ACKing the address
    clear_counts();
    i2c_start();
    send_bits(8'hA0, 8, -1);
    wait_clks(Q);
    check("s7_oe_before_reset", sda_oe, 1);
    do_reset();
    check("s7_oe", sda_oe, 0);
    check("s7_busy", busy, 0);
    check("s7_addr_match", addr_match, 0);
    check("s7_rx_data", rx_data, 8'h00);
    sda_drv = 1'b1;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(LAT + 6);
    check("s7_idle_busy", busy, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_byte_rx.md
I2C_BYTE_RX -- requirements
Module: i2c_byte_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this receiver acknowledges.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port scl_in  input  1  I2C SCL as seen on the bus, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  I2C SDA as seen on the bus, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-007 SHALL have port rx_full  input  1  consumer cannot accept a byte; received byte is NACKed.
REQ-008 SHALL have port rx_data  output  8  last accepted data byte, MSB-first assembly.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse; rx_data newly valid.
REQ-010 SHALL have port busy  output  1  high from detected START to detected STOP.
REQ-011 SHALL have port addr_match  output  1  high from address ACK until next START or STOP.

Function
REQ-012 SHALL pass scl_in/sda_in through a 2-flop synchronizer, then one delay register; edges and conditions are derived from synchronized (s) and delayed (d) values.
REQ-013 SHALL define SCL rise = scl_s & ~scl_d, SCL fall = ~scl_s & scl_d, START = scl_s & scl_d & sda_d & ~sda_s, STOP = scl_s & scl_d & ~sda_d & sda_s.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 SHALL, on START in any state (including repeated START), go to ADDR, clear the 3-bit bit counter and the shift register, clear addr_match, and set busy.
REQ-016 SHALL, on STOP in any state, go to IDLE, release sda_oe, and clear busy and addr_match in that same cycle.
REQ-017 SHALL give START/STOP priority over SCL-edge processing in the same cycle.
REQ-018 SHALL, in ADDR and DATA, shift sda_s into the shift register LSB on each SCL rise; the counter wraps 7->0 after the 8th bit.
REQ-019 SHALL, on the 8th ADDR bit, go to ADDR_ACK if bits[7:1]==SLAVE_ADDR and bit0==0; otherwise go to IGNORE. Read requests are never ACKed.
REQ-020 SHALL, in ADDR_ACK/DATA_ACK with ACK decided, assert sda_oe on the next SCL fall and release it on the following SCL fall, then go to DATA.
REQ-021 SHALL set addr_match on entry to ADDR_ACK.
REQ-022 SHALL, on the 8th DATA bit with rx_full=0, load rx_data and pulse rx_valid for exactly one clk in the following cycle, then go to DATA_ACK with ACK.
REQ-023 SHALL, on the 8th DATA bit with rx_full=1, leave rx_data unchanged, not pulse rx_valid, never assert sda_oe (NACK), and go to IGNORE.
REQ-024 SHALL, in IGNORE, keep sda_oe=0 and ignore SCL edges until START or STOP.
REQ-025 SHALL not leave IDLE on SCL edges alone.
REQ-026 SHALL have a latency of 3 clk from a pin change to edge/condition detection (without the filter); the SCL period SHALL be at least 16 clk.

Reset
REQ-027 SHALL, with reset low at a clk edge, enter IDLE with sda_oe=0, rx_valid=0, rx_data=8'h00, busy=0, addr_match=0, counter=0.
REQ-028 SHALL preset the synchronizer, delay, and filter registers to 1 (idle bus), so reset release produces no false START or STOP.
REQ-029 SHALL abort any transfer on reset mid-byte, release SDA immediately, and discard partial data.

Configuration
REQ-030 SHALL support macro I2C_RX_GLITCH_FILTER_EN: when defined, a synchronized SCL/SDA change is accepted only after 3 consecutive equal samples, adding 2 clk latency and rejecting pulses of 2 clk or less; when undefined, the 2-flop synchronizer output is used directly.

Verification
REQ-031 SHALL verify write to 0x50 (byte 0xA0) then data 0x3C then STOP -> ACK on both bytes, rx_valid pulses once with rx_data=0x3C, busy falls after STOP.
REQ-032 SHALL verify address 0x51 write -> no sda_oe, addr_match=0, no rx_valid, IGNORE until STOP.
REQ-033 SHALL verify address 0x50 read (0xA1) -> NACK, no rx_valid.
REQ-034 SHALL verify 0x50 write, data 0x11 ACKed, then rx_full=1 with data 0x22 -> NACK, rx_data stays 0x11.
REQ-035 SHALL verify 0x50 write, 4 data bits, then repeated START and 0x50 write + 0x5A -> rx_data=0x5A, single rx_valid.
REQ-036 SHALL verify that a 1-clk SDA glitch during SCL high with I2C_RX_GLITCH_FILTER_EN defined -> no START/STOP detected; without the macro -> STOP detected, state IDLE.
